// File: rtl/keypad_digit_capture.sv
// keypad_digit_capture
// Turns a confirmed keypad press (row index + column snapshot) into a hex key
// value and shifts it into a two-digit history for the seven-segment mux.
// Ambiguous column snapshots are rejected with a strobe. Accepted presses are
// tallied in a saturating counter.
module keypad_digit_capture #(
  parameter logic [3:0] RESET_DIGIT = 4'h0,
  parameter int         COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse,
  input  logic [1:0]         row_sel,
  input  logic [3:0]         cols,
  output logic [3:0]         new_digit,
  output logic [3:0]         old_digit,
  output logic               digit_valid,
  output logic               invalid_press,
  output logic [COUNT_W-1:0] press_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_UPDATE = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [1:0]           r_row;
  logic [3:0]           r_cols;
  logic [3:0]           r_key;
  logic [3:0]           r_new_digit;
  logic [3:0]           r_old_digit;
  logic                 r_digit_valid;
  logic                 r_invalid_press;
  logic [COUNT_W-1:0]   r_press_count;

  logic                 w_one_hot;
  logic [1:0]           w_col_idx;
  logic [3:0]           w_key;
  logic                 w_count_max;

  // Exactly one column high means the press is unambiguous.
  assign w_one_hot   = (r_cols != 4'd0) && ((r_cols & (r_cols - 4'd1)) == 4'd0);
  assign w_count_max = &r_press_count;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accept only from IDLE, one decode cycle, one commit cycle.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves the
    // signal unassigned, which would infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (pulse) w_next_state = S_DECODE;
      S_DECODE: w_next_state = w_one_hot ? S_UPDATE : S_REJECT;
      S_UPDATE: w_next_state = S_IDLE;
      S_REJECT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Column index of the single high bit (only meaningful when w_one_hot).
  always_comb begin
    w_col_idx = 2'd0;
    case (r_cols)
      4'b0001: w_col_idx = 2'd0;
      4'b0010: w_col_idx = 2'd1;
      4'b0100: w_col_idx = 2'd2;
      4'b1000: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Keypad legend lookup: {row, column} -> hex key value.
  always_comb begin
    w_key = 4'h0;
    case ({r_row, w_col_idx})
      4'b00_00: w_key = 4'h1;
      4'b00_01: w_key = 4'h2;
      4'b00_10: w_key = 4'h3;
      4'b00_11: w_key = 4'hA;
      4'b01_00: w_key = 4'h4;
      4'b01_01: w_key = 4'h5;
      4'b01_10: w_key = 4'h6;
      4'b01_11: w_key = 4'hB;
      4'b10_00: w_key = 4'h7;
      4'b10_01: w_key = 4'h8;
      4'b10_10: w_key = 4'h9;
      4'b10_11: w_key = 4'hC;
      4'b11_00: w_key = 4'hE;
      4'b11_01: w_key = 4'h0;
      4'b11_10: w_key = 4'hF;
      4'b11_11: w_key = 4'hD;
      default:  w_key = 4'h0;
    endcase
  end

  // Snapshot row/columns at the accepting edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    // NOTE: the capture registers are reset too so a press discarded by reset
    // can never leave stale data behind for the decode stage.
    if (reset) begin
      r_row  <= 2'd0;
      r_cols <= 4'd0;
    end else if (r_state == S_IDLE && pulse) begin
      r_row  <= row_sel;
      r_cols <= cols;
    end
  end

  // Register the decoded key during DECODE for use in UPDATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key <= 4'h0;
    end else if (r_state == S_DECODE) begin
      r_key <= w_key;
    end
  end

  // Digit history, saturating counter and one-cycle result strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_new_digit     <= RESET_DIGIT;
      r_old_digit     <= RESET_DIGIT;
      r_digit_valid   <= 1'b0;
      r_invalid_press <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_digit_valid   <= (r_state == S_UPDATE);
      r_invalid_press <= (r_state == S_REJECT);
      if (r_state == S_UPDATE) begin
        r_old_digit <= r_new_digit;
        r_new_digit <= r_key;
        if (!w_count_max) begin
          r_press_count <= r_press_count + COUNT_W'(1);
        end
      end
    end
  end

  assign new_digit     = r_new_digit;
  assign old_digit     = r_old_digit;
  assign digit_valid   = r_digit_valid;
  assign invalid_press = r_invalid_press;
  assign press_count   = r_press_count;

endmodule
